// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter.
//   state_e     : arbiter FSM encoding (idle, owned by requester 0, owned by requester 1)
//   count_width : width of a counter that must hold 0..max_burst inclusive
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  function automatic int unsigned count_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mux2x1.sv
// Generic 2:1 data multiplexer.
//   size      : width of each input word
//   inputVal  : {in1, in0}, packed side by side
//   sel       : 0 picks in0, 1 picks in1
//   outputVal : selected word
module mux2x1 #(
  parameter int unsigned size = 8
) (
  input  logic [2*size-1:0] inputVal,
  input  logic              sel,
  output logic [size-1:0]   outputVal
);

  assign outputVal = sel ? inputVal[2*size-1:size] : inputVal[size-1:0];

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter driving a shared 2:1 data path.
// An owner keeps the path until it signals done on a transfer, drops its request,
// or uses up MAX_BURST transfers while the other side is waiting. Ties from idle
// go to the side that did not own the path last.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req0/1, data0/1       : requester request and payload
//   done0/1               : owner releases after the current transfer
//   gnt0/1, sel           : registered ownership and data-path select
//   out_valid, out_data   : shared-path output; out_ready accepts it
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic [SIZE-1:0] data0,
  input  logic [SIZE-1:0] data1,
  input  logic            done0,
  input  logic            done1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            sel,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  input  logic            out_ready
);

  localparam int unsigned     CntW    = count_width(MAX_BURST);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BURST);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

  state_e          state_q;
  logic            sel_q;
  logic            last_owner_q;
  logic [CntW-1:0] count_q;

  logic own_req, other_req, own_done;
  logic xfer, release_own;
  logic grant_new, new_owner, go_idle;

  // Route the current owner's signals; the non-owner's done/data never matter.
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    own_done  = 1'b0;
    case (state_q)
      StOwn0: begin
        own_req   = req0;
        other_req = req1;
        own_done  = done0;
      end
      StOwn1: begin
        own_req   = req1;
        other_req = req0;
        own_done  = done1;
      end
      default: ;
    endcase
  end

  assign out_valid = own_req;
  assign xfer      = out_valid & out_ready;

  // Burst limit only forces a handoff when the other side is actually waiting.
  assign release_own = (xfer & own_done) | ~own_req |
                       (xfer & other_req & (count_q >= LastCnt));

  always_comb begin
    grant_new = 1'b0;
    new_owner = 1'b0;
    go_idle   = 1'b0;
    if (state_q == StIdle) begin
      grant_new = req0 | req1;
      new_owner = ~(req0 & (~req1 | last_owner_q));
    end else if (release_own) begin
      grant_new = other_req;
      new_owner = (state_q == StOwn0);
      go_idle   = ~other_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= 1'b0;
      last_owner_q <= 1'b1;
      count_q      <= '0;
    end else if (grant_new) begin
      state_q      <= new_owner ? StOwn1 : StOwn0;
      sel_q        <= new_owner;
      last_owner_q <= new_owner;
      count_q      <= '0;
    end else if (go_idle) begin
      state_q <= StIdle;
    end else if (xfer && (count_q != MaxCnt)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign gnt0 = (state_q == StOwn0);
  assign gnt1 = (state_q == StOwn1);
  assign sel  = sel_q;

  mux2x1 #(
    .size(SIZE)
  ) u_mux (
    .inputVal ({data1, data0}),
    .sel      (sel_q),
    .outputVal(out_data)
  );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, alternating bursts, single requester
// with done, stalled done, burst saturation handoff, and reset mid-burst.
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       done0, done1;
  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int total;
  int bad;

  logic [11:0] got, exp;

  mux_arbiter #(
    .SIZE     (8),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .data0    (data0),
    .data1    (data1),
    .done0    (done0),
    .done1    (done1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Invariants checked every cycle on the falling edge.
  always @(negedge clk) begin
    total++;
    if ((gnt0 & gnt1) || (out_valid && !(gnt0 | gnt1))) begin
      bad++;
      $display("FAIL invariant: gnt0=%b gnt1=%b out_valid=%b at %0t", gnt0, gnt1, out_valid,
               $time);
    end
  end

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    got = {gnt0, gnt1, sel, out_valid, out_data & 8'h00};
    exp = 12'h000;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", got, exp);
    end
    req0 = 1'b1;
    tick();
    total++;
    if ({gnt0, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hold: got %b want 00", {gnt0, out_valid});
    end
    req0  = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  // Both requesting: OWN0 x4, OWN1 x4, ... with no idle gap.
  task automatic test_alternate();
    logic o;
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1; data0 = 8'h11; data1 = 8'h22;
    #3;
    total++;
    if ({gnt0, gnt1, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL alt_idle: got %b want 000", {gnt0, gnt1, out_valid});
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      #3;
      o   = (((i / 4) % 2) == 1);
      exp = {~o, o, o, 1'b1, o ? 8'h22 : 8'h11};
      got = {gnt0, gnt1, sel, out_valid, out_data};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL alt_cycle%0d: got %h want %h", i, got, exp);
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #3;
    total++;
    if ({gnt0, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL alt_drop: got %b want 10", {gnt0, out_valid});
    end
    tick();
    #3;
    total++;
    if ({gnt0, gnt1, sel, out_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL alt_to_idle: got %b want 0000", {gnt0, gnt1, sel, out_valid});
    end
    tick();
  endtask

  // req1 alone, done1 on the second transfer; requester 0's done/data ignored.
  task automatic test_single_req1();
    int nxfer;
    nxfer = 0;
    req1 = 1'b1; data1 = 8'hA5; data0 = 8'h3C; done0 = 1'b1; out_ready = 1'b1;
    #3;
    total++;
    if (gnt1 !== 1'b0) begin
      bad++;
      $display("FAIL single_no_early_gnt: got %b want 0", gnt1);
    end
    nxfer += int'(out_valid & out_ready);
    tick();
    #3;
    got = {gnt0, gnt1, sel, out_valid, out_data};
    exp = {4'b0111, 8'hA5};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL single_first: got %h want %h", got, exp);
    end
    nxfer += int'(out_valid & out_ready);
    tick();
    done1 = 1'b1;
    #3;
    total++;
    if ({gnt1, out_data} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL single_second: got %h want 1a5", {gnt1, out_data});
    end
    nxfer += int'(out_valid & out_ready);
    tick();
    req1 = 1'b0; done1 = 1'b0; done0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      total++;
      if ({gnt0, gnt1, sel, out_valid} !== 4'b0010) begin
        bad++;
        $display("FAIL single_idle%0d: got %b want 0010", i, {gnt0, gnt1, sel, out_valid});
      end
      nxfer += int'(out_valid & out_ready);
      tick();
    end
    total++;
    if (nxfer != 2) begin
      bad++;
      $display("FAIL single_xfer_count: got %0d want 2", nxfer);
    end
  endtask

  // done0 held while out_ready is low must not release.
  task automatic test_ready_stall();
    req0 = 1'b1; done0 = 1'b1; out_ready = 1'b0; data0 = 8'h5A;
    tick();
    for (int i = 0; i < 3; i++) begin
      #3;
      got = {gnt0, gnt1, sel, out_valid, out_data};
      exp = {4'b1001, 8'h5A};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stall_cycle%0d: got %h want %h", i, got, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    #3;
    total++;
    if ({gnt0, out_valid} !== 2'b11) begin
      bad++;
      $display("FAIL stall_xfer: got %b want 11", {gnt0, out_valid});
    end
    tick();
    req0 = 1'b0; done0 = 1'b0;
    #3;
    total++;
    if ({gnt0, gnt1, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL stall_release: got %b want 000", {gnt0, gnt1, out_valid});
    end
    tick();
  endtask

  // Lone owner keeps going past MAX_BURST; handoff after one more transfer.
  task automatic test_saturate();
    req0 = 1'b1; req1 = 1'b0; out_ready = 1'b1; data0 = 8'h0F; data1 = 8'hC3;
    tick();
    for (int i = 0; i < 10; i++) begin
      #3;
      total++;
      if ({gnt0, gnt1, out_valid} !== 3'b101) begin
        bad++;
        $display("FAIL sat_hold%0d: got %b want 101", i, {gnt0, gnt1, out_valid});
      end
      tick();
    end
    req1 = 1'b1;
    #3;
    total++;
    if ({gnt0, gnt1, out_data} !== {2'b10, 8'h0F}) begin
      bad++;
      $display("FAIL sat_last_own0: got %h want 20f", {gnt0, gnt1, out_data});
    end
    tick();
    req0 = 1'b0;
    #3;
    got = {gnt0, gnt1, sel, out_valid, out_data};
    exp = {4'b0111, 8'hC3};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sat_handoff: got %h want %h", got, exp);
    end
    tick();
  endtask

  // Reset during an OWN1 burst with count=2; both requesting afterwards.
  task automatic test_reset_mid();
    #3;
    total++;
    if ({gnt1, out_valid} !== 2'b11) begin
      bad++;
      $display("FAIL rmid_own1: got %b want 11", {gnt1, out_valid});
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, sel, out_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_async: got %b want 0000", {gnt0, gnt1, sel, out_valid});
    end
    req0 = 1'b1; req1 = 1'b1;
    tick();
    total++;
    if ({gnt0, gnt1, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL rmid_held: got %b want 000", {gnt0, gnt1, out_valid});
    end
    rst_n = 1'b1;
    #3;
    total++;
    if ({gnt0, gnt1} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_idle: got %b want 00", {gnt0, gnt1});
    end
    tick();
    #3;
    total++;
    if ({gnt0, gnt1, sel, out_valid} !== 4'b1001) begin
      bad++;
      $display("FAIL rmid_first_grant: got %b want 1001", {gnt0, gnt1, sel, out_valid});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    done0 = 1'b0; done1 = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_alternate();
    test_single_req1();
    test_ready_stall();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 8: requester data width in bits.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum consecutive transfers per ownership while the other side requests; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have ports req0, req1  input  1 each  requester wants the shared path.
REQ-006 SHALL have ports data0, data1  input  SIZE each  requester payload.
REQ-007 SHALL have ports done0, done1  input  1 each  requester releases after the current transfer.
REQ-008 SHALL have ports gnt0, gnt1  output  1 each  registered ownership indication.
REQ-009 SHALL have port sel  output  1  registered select of the shared 2:1 data path.
REQ-010 SHALL have port out_valid  output  1  shared-path data valid.
REQ-011 SHALL have port out_data  output  SIZE  shared-path payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.

Function
REQ-013 SHALL implement states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1); never both high.
REQ-014 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> side != last_owner; none -> stay. Grant visible the cycle after the request is sampled.
REQ-015 On entering OWNx: sel = x, last_owner = x, burst count = 0.
REQ-016 In OWNx: out_valid = reqx (combinational); out_data = datax via sel; no other condition gates out_valid.
REQ-017 Burst count SHALL increment on each transfer, saturating at MAX_BURST; width = clog2(MAX_BURST+1).
REQ-018 Release from OWNx occurs when: (a) transfer with donex=1, (b) reqx=0, or (c) transfer with count reaching MAX_BURST while the other req is high.
REQ-019 On release: if the other req is high -> go directly to the other OWN state (no IDLE bubble); else -> IDLE.
REQ-020 Count reaching MAX_BURST with the other req low SHALL NOT release; owner continues, count held saturated.
REQ-021 donex with no transfer (out_ready=0) SHALL NOT release; donex is sampled only on a transfer cycle.
REQ-022 sel SHALL hold its last value in IDLE; out_valid=0 in IDLE.
REQ-023 done/data of the non-owner SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, gnt0=gnt1=0, sel=0, out_valid=0, count=0, last_owner=1 (req0 wins first tie).
REQ-025 Reset mid-burst SHALL abandon the burst; no transfer on any cycle rst_n is low; first grant after release follows REQ-014.

Structure
REQ-026 State encoding (IDLE/OWN0/OWN1) and the count-width function SHALL live in the shared processor package.
REQ-027 Data path SHALL instantiate the existing mux2x1 (size=SIZE, inputVal={data1,data0}, sel=sel); no duplicate mux logic.
REQ-028 Arbiter FSM, counter and last_owner register SHALL be in this module; no further sub-modules.

Verification
REQ-029 Reset then req0=req1=1, out_ready=1, done=0, MAX_BURST=4 -> OWN0 4 transfers, then OWN1 4 transfers, alternating, no IDLE cycle.
REQ-030 req1 only, data1=8'hA5, out_ready=1, done1 on 2nd transfer -> gnt1 one cycle after req1, out_data=8'hA5, exactly 2 transfers, then IDLE.
REQ-031 OWN0, out_ready=0 for 3 cycles with done0=1 -> no release, gnt0 held; out_ready=1 -> one transfer, release.
REQ-032 req0 alone for 10 transfers -> gnt0 held throughout, count saturates at 4; req1 rises -> handoff after next transfer.
REQ-033 rst_n low mid-OWN1 burst (count=2) -> gnt1, out_valid, sel fall immediately; after release with both req -> OWN0 granted.
REQ-034 Every cycle: assert !(gnt0&gnt1) and out_valid implies (gnt0|gnt1).
